exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the RV32IM core. Consumes the ID/EXE pipeline register outputs (pc, inst, imm, operands, predictor bit).
- Computes the ALU/MUL result and resolves branches and jumps, raising a redirect on misprediction.
- Runs DIV/DIVU/REM/REMU on an internal 32-iteration radix-2 divider FSM. While it runs, it holds the upstream pipeline with stall_req.
- Outputs feed the EXE/MEM register and the hazard/flush controller.

Parameters:
addrWidth, 15, width of pc and redirect_pc in bits

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
flush  input  1  external kill (trap/upper redirect); aborts divider and masks outputs this cycle
pc  input  addrWidth  pc of instruction in EXE
inst  input  32  instruction in EXE; 32'd0 is a bubble
imm  input  32  decoded immediate
rs1_rdata  input  32  forwarded rs1 operand
rs2_rdata  input  32  forwarded rs2 operand
BP_taken  input  1  predictor's taken decision made at fetch
exe_result  output  32  result for EXE/MEM register
result_valid  output  1  exe_result valid and instruction may retire to MEM this cycle
stall_req  output  1  hold PC/IF/ID/EXE registers, insert bubble into MEM
redirect  output  1  mispredict: flush younger stages, refetch at redirect_pc
redirect_pc  output  addrWidth  correct next pc

Behaviour:
- Valid instruction: inst != 0 and opcode is in {OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE}. Anything else: result_valid=0, redirect=0, no divider start.
- ALU, combinational: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND and their immediate forms.
  - Shift amount is operand[4:0].
  - LOAD/STORE: exe_result = rs1+imm (address).
  - LUI: imm. AUIPC: zero-extended pc + imm.
- MUL/MULH/MULHSU/MULHU: single cycle, full 64-bit product, upper or lower 32 bits selected per funct3.
- JAL/JALR: exe_result = zero-extended (pc+4).
  - JAL target = pc+imm.
  - JALR target = (rs1+imm) & ~1.
  - Targets are truncated to addrWidth.
- BRANCH: taken per BEQ/BNE/BLT/BGE/BLTU/BGEU on rs1/rs2; target = pc+imm.
- actual_taken: 1 for JAL/JALR, compare result for branches, 0 otherwise.
- redirect = valid & !flush & ((actual_taken != BP_taken) | JALR).
- redirect_pc = actual_taken ? target : pc+4, modulo 2^addrWidth. Combinational, same cycle.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE, valid div op, !flush:
    - If divisor == 0: quotient = 32'hFFFFFFFF, remainder = dividend. Go to DONE.
    - Else if signed op and dividend = 32'h80000000 and divisor = -1: quotient = 32'h80000000, remainder = 0. Go to DONE.
    - Otherwise latch |operands| and sign flags, count = 0, go to BUSY.
    - stall_req = 1 in this cycle.
  - BUSY: one restoring shift-subtract per cycle, count increments. After count 31 the sign-correct result is registered and the FSM goes to DONE. stall_req = 1 throughout.
  - DONE: stall_req = 0, result_valid = 1, exe_result = registered quotient or remainder. Next cycle goes to IDLE (Reg_E has advanced).
  - Latency for a normal div: 1 (IDLE) + 32 (BUSY) + 1 (DONE) = 34 cycles in EXE. Div-by-zero and overflow take 2 cycles.
  - Signs: quotient is negative iff operand signs differ and divisor != 0. Remainder takes the dividend's sign.
- Non-div instructions: stall_req = 0 and result_valid = valid.
- flush = 1 in any state: FSM goes to IDLE next edge, stall_req = 0, result_valid = 0, redirect = 0 this cycle.
- rst, asynchronous:
  - FSM = IDLE; count, quotient and remainder registers = 0.
  - Outputs settle to stall_req=0, redirect=0, result_valid=0, exe_result=0, redirect_pc=0, with the bubble in EXE (inst = 0).
  - Reset mid-divide discards the operation.
- stall_req and redirect are never both 1: branches never stall.

Test Plan:
- ADD x3=rs1 5, rs2 -7 (inst 0x002081B3) -> exe_result 0xFFFFFFFE, result_valid 1, stall_req 0, redirect 0.
- BEQ rs1=rs2=9, imm 16, pc 0x100, BP_taken 0 -> redirect 1, redirect_pc 0x110. Same with BP_taken 1 -> redirect 0.
- JALR rs1 0x203, imm 4, pc 0x40 -> exe_result 0x44, redirect 1, redirect_pc 0x206.
- DIV -7/2 held by stall -> stall_req 1 for exactly 33 cycles, then DONE with exe_result 0xFFFFFFFD. REM of the same operands gives 0xFFFFFFFF.
- DIVU 10/0 -> stall 1 cycle, then 0xFFFFFFFF. DIV 0x80000000/-1 -> 0x80000000. REM 0x80000000/-1 -> 0.
- Assert flush, then rst, at BUSY cycle 10 -> each returns to IDLE, stall_req 0 on the next edge (rst immediately). A following ADD completes normally.

Source files
------------

// File: rtl/exe_stage.sv
// RV32IM execute stage: ALU/MUL, branch/jump resolution with redirect, and a
// 32-iteration restoring divider that holds the upstream pipeline while busy.
module exe_stage #(
    parameter int addrWidth = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [addrWidth-1:0] pc,
    input  logic [31:0]          inst,
    input  logic [31:0]          imm,
    input  logic [31:0]          rs1_rdata,
    input  logic [31:0]          rs2_rdata,
    input  logic                 BP_taken,
    output logic [31:0]          exe_result,
    output logic                 result_valid,
    output logic                 stall_req,
    output logic                 redirect,
    output logic [addrWidth-1:0] redirect_pc
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
    div_state_t state_reg, state_next;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    logic is_op, is_jal, is_jalr, is_branch, valid, is_mul, is_div;
    assign is_op     = (opcode == OPC_OP);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_branch = (opcode == OPC_BRANCH);
    assign valid = (inst != 32'd0) &&
                   (is_op || opcode == OPC_OPIMM || opcode == OPC_LUI || opcode == OPC_AUIPC ||
                    is_jal || is_jalr || is_branch || opcode == OPC_LOAD || opcode == OPC_STORE);
    assign is_mul = is_op && (funct7 == 7'b0000001) && !funct3[2];
    assign is_div = is_op && (funct7 == 7'b0000001) && funct3[2];

    // ALU; inst[30] only selects SUB/SRA for register ops and for SRAI
    logic [31:0] op_b, alu_result;
    logic [4:0]  shamt;
    logic        alt;
    assign op_b  = is_op ? rs2_rdata : imm;
    assign shamt = op_b[4:0];
    assign alt   = inst[30] && (is_op || funct3 == 3'b101);

    always_comb begin
        alu_result = 32'd0;
        case (funct3)
            3'b000: alu_result = alt ? rs1_rdata - op_b : rs1_rdata + op_b;
            3'b001: alu_result = rs1_rdata << shamt;
            3'b010: alu_result = {31'd0, $signed(rs1_rdata) < $signed(op_b)};
            3'b011: alu_result = {31'd0, rs1_rdata < op_b};
            3'b100: alu_result = rs1_rdata ^ op_b;
            3'b101: alu_result = alt ? 32'($signed(rs1_rdata) >>> shamt) : rs1_rdata >> shamt;
            3'b110: alu_result = rs1_rdata | op_b;
            default: alu_result = rs1_rdata & op_b;
        endcase
    end

    // One 33x33 signed multiply covers MULH/MULHSU/MULHU via operand extension
    logic               a_sgn, b_sgn;
    logic signed [65:0] mul_full;
    logic [31:0]        mul_result;
    assign a_sgn      = (funct3 != 3'b011);
    assign b_sgn      = !funct3[1];
    assign mul_full   = $signed({a_sgn & rs1_rdata[31], rs1_rdata}) *
                        $signed({b_sgn & rs2_rdata[31], rs2_rdata});
    assign mul_result = (funct3 == 3'b000) ? mul_full[31:0] : mul_full[63:32];

    // Branch / jump resolution
    logic                 cmp_taken, actual_taken;
    logic [31:0]          jalr_sum;
    logic [addrWidth-1:0] pc_plus4, target;
    always_comb begin
        cmp_taken = 1'b0;
        case (funct3)
            3'b000: cmp_taken = (rs1_rdata == rs2_rdata);
            3'b001: cmp_taken = (rs1_rdata != rs2_rdata);
            3'b100: cmp_taken = ($signed(rs1_rdata) < $signed(rs2_rdata));
            3'b101: cmp_taken = ($signed(rs1_rdata) >= $signed(rs2_rdata));
            3'b110: cmp_taken = (rs1_rdata < rs2_rdata);
            3'b111: cmp_taken = (rs1_rdata >= rs2_rdata);
            default: cmp_taken = 1'b0;
        endcase
    end
    assign actual_taken = is_jal || is_jalr || (is_branch && cmp_taken);
    assign jalr_sum     = rs1_rdata + imm;
    assign pc_plus4     = pc + addrWidth'(4);
    assign target       = is_jalr ? {jalr_sum[addrWidth-1:1], 1'b0} : pc + imm[addrWidth-1:0];

    logic [31:0] pc32, main_result;
    assign pc32 = {{(32 - addrWidth){1'b0}}, pc};
    always_comb begin
        main_result = 32'd0;
        case (opcode)
            OPC_OP:              main_result = is_mul ? mul_result : alu_result;
            OPC_OPIMM:           main_result = alu_result;
            OPC_LUI:             main_result = imm;
            OPC_AUIPC:           main_result = pc32 + imm;
            OPC_JAL, OPC_JALR:   main_result = {{(32 - addrWidth){1'b0}}, pc_plus4};
            OPC_LOAD, OPC_STORE: main_result = rs1_rdata + imm;
            default:             main_result = 32'd0;
        endcase
    end

    // Divider: quot_reg shifts dividend bits out while quotient bits shift in
    logic [4:0]  count_reg;
    logic [31:0] quot_reg, rem_reg, divisor_reg;
    logic        neg_q_reg, neg_r_reg;
    logic        div_signed, div_by_zero, div_ovf, div_start;
    logic [31:0] dividend_abs, divisor_abs, step_rem, step_quot;
    logic [32:0] step_shift, step_diff;
    logic        step_ge;

    assign div_signed   = !funct3[0];
    assign div_by_zero  = (rs2_rdata == 32'd0);
    assign div_ovf      = div_signed && rs1_rdata == 32'h8000_0000 && rs2_rdata == 32'hFFFF_FFFF;
    assign div_start    = valid && is_div && !flush && state_reg == IDLE;
    assign dividend_abs = (div_signed && rs1_rdata[31]) ? 32'd0 - rs1_rdata : rs1_rdata;
    assign divisor_abs  = (div_signed && rs2_rdata[31]) ? 32'd0 - rs2_rdata : rs2_rdata;
    assign step_shift   = {rem_reg, quot_reg[31]};
    assign step_diff    = step_shift - {1'b0, divisor_reg};
    assign step_ge      = !step_diff[32];
    assign step_rem     = step_ge ? step_diff[31:0] : step_shift[31:0];
    assign step_quot    = {quot_reg[30:0], step_ge};

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (valid && is_div) state_next = (div_by_zero || div_ovf) ? DONE : BUSY;
                BUSY:    if (count_reg == 5'd31) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg   <= 5'd0;
            quot_reg    <= 32'd0;
            rem_reg     <= 32'd0;
            divisor_reg <= 32'd0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
        end else if (div_start) begin
            if (div_by_zero) begin
                quot_reg <= 32'hFFFF_FFFF;
                rem_reg  <= rs1_rdata;
            end else if (div_ovf) begin
                quot_reg <= 32'h8000_0000;
                rem_reg  <= 32'd0;
            end else begin
                quot_reg    <= dividend_abs;
                rem_reg     <= 32'd0;
                divisor_reg <= divisor_abs;
                neg_q_reg   <= div_signed && (rs1_rdata[31] ^ rs2_rdata[31]);
                neg_r_reg   <= div_signed && rs1_rdata[31];
                count_reg   <= 5'd0;
            end
        end else if (state_reg == BUSY && !flush) begin
            count_reg <= count_reg + 5'd1;
            if (count_reg == 5'd31) begin
                quot_reg <= neg_q_reg ? 32'd0 - step_quot : step_quot;
                rem_reg  <= neg_r_reg ? 32'd0 - step_rem : step_rem;
            end else begin
                quot_reg <= step_quot;
                rem_reg  <= step_rem;
            end
        end
    end

    always_comb begin
        exe_result   = 32'd0;
        result_valid = 1'b0;
        stall_req    = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = valid ? (actual_taken ? target : pc_plus4) : '0;
        if (valid && !flush) begin
            if (is_div) begin
                if (state_reg == DONE) begin
                    result_valid = 1'b1;
                    exe_result   = funct3[1] ? rem_reg : quot_reg;
                end else begin
                    stall_req = 1'b1;
                end
            end else begin
                result_valid = 1'b1;
                exe_result   = main_result;
                redirect     = (actual_taken != BP_taken) || is_jalr;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{inst[24:15], inst[11:7], mul_full[65:64],
                           jalr_sum[31:addrWidth], jalr_sum[0]};
endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: per-feature tasks with a result scoreboard.
module tb_exe_stage;
    localparam int AW = 15;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_DIV  = 32'h0220C1B3;
    localparam logic [31:0] I_DIVU = 32'h0220D1B3;
    localparam logic [31:0] I_REM  = 32'h0220E1B3;
    localparam logic [31:0] I_REMU = 32'h0220F1B3;

    logic          clk = 1'b0;
    logic          rst, flush, BP_taken;
    logic [AW-1:0] pc;
    logic [31:0]   inst, imm, rs1_rdata, rs2_rdata;
    logic [31:0]   exe_result;
    logic          result_valid, stall_req, redirect;
    logic [AW-1:0] redirect_pc;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    exe_stage #(.addrWidth(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .pc(pc), .inst(inst), .imm(imm),
        .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata), .BP_taken(BP_taken),
        .exe_result(exe_result), .result_valid(result_valid), .stall_req(stall_req),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    typedef struct packed {
        logic [31:0] inst, a, b, imm, exp;
    } alu_vec_t;

    typedef struct packed {
        logic [31:0]   inst, a, b, imm;
        logic [AW-1:0] pc;
        logic          bp, exp_redir;
        logic [AW-1:0] exp_pc;
    } br_vec_t;

    typedef struct packed {
        logic [31:0] inst, a, b, exp;
        int          stalls;
    } div_vec_t;

    task automatic drive(input logic [31:0] i, a, b, im, input logic [AW-1:0] p, input logic bp);
        inst = i; rs1_rdata = a; rs2_rdata = b; imm = im; pc = p; BP_taken = bp;
    endtask

    // Starts one divide from posedge+1 and follows it until stall_req drops.
    task automatic run_div(input logic [31:0] i, a, b, output int stalls, output logic done,
                           output logic [31:0] res, output logic overlap);
        drive(i, a, b, 32'd0, 15'h100, 1'b0);
        stalls = 0; done = 1'b0; res = 32'd0; overlap = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (stall_req === 1'b1 && redirect === 1'b1) overlap = 1'b1;
            if (stall_req === 1'b1) begin
                stalls++;
            end else begin
                done = (result_valid === 1'b1);
                res  = exe_result;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        drive(32'd0, 32'd0, 32'd0, 32'd0, '0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 32'd0, '0, 1'b0);
        #3;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got=%b exp=0", redirect); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
        checks++; if (exe_result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", exe_result); end
        checks++; if (redirect_pc !== '0) begin errors++; $display("FAIL reset_rpc got=%h exp=0", redirect_pc); end
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (stall_req !== 1'b0 || result_valid !== 1'b0) begin
            errors++; $display("FAIL bubble_after_reset got stall=%b valid=%b exp 0/0", stall_req, result_valid);
        end
        $display("txn reset done");
    endtask

    task automatic test_alu();
        alu_vec_t v[17];
        logic [31:0] e;
        v[0]  = '{I_ADD,        32'd5,        32'hFFFFFFF9, 32'd0,        32'hFFFFFFFE};
        v[1]  = '{32'h402081B3, 32'd5,        32'hFFFFFFF9, 32'd0,        32'h0000000C};
        v[2]  = '{32'h4000D193, 32'h80000000, 32'd0,        32'h00000404, 32'hF8000000};
        v[3]  = '{32'hC0008193, 32'd5,        32'd0,        32'hFFFFFC00, 32'hFFFFFC05};
        v[4]  = '{32'h0020B1B3, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd1};
        v[5]  = '{32'h0020A1B3, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd1};
        v[6]  = '{32'h002091B3, 32'd1,        32'h00000023, 32'd0,        32'd8};
        v[7]  = '{32'h0020C1B3, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'h0FF00FF0};
        v[8]  = '{32'h0020D1B3, 32'h80000000, 32'd4,        32'd0,        32'h08000000};
        v[9]  = '{32'h000001B7, 32'd0,        32'd0,        32'h12345000, 32'h12345000};
        v[10] = '{32'h00000197, 32'd0,        32'd0,        32'h00001000, 32'h00001100};
        v[11] = '{32'h0000A183, 32'h00001000, 32'd0,        32'hFFFFFFFC, 32'h00000FFC};
        v[12] = '{32'h0020A023, 32'h00000010, 32'd0,        32'd8,        32'h00000018};
        v[13] = '{32'h022081B3, 32'hFFFFFFFD, 32'd7,        32'd0,        32'hFFFFFFEB};
        v[14] = '{32'h022091B3, 32'hFFFFFFFD, 32'd7,        32'd0,        32'hFFFFFFFF};
        v[15] = '{32'h0220A1B3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF};
        v[16] = '{32'h0220B1B3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFE};
        for (int k = 0; k < 17; k++) begin
            @(posedge clk); #1;
            drive(v[k].inst, v[k].a, v[k].b, v[k].imm, 15'h100, 1'b0);
            exp_q.push_back(v[k].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL alu_valid[%0d] got=%b exp=1", k, result_valid); end
            checks++; if (stall_req !== 1'b0 || redirect !== 1'b0) begin
                errors++; $display("FAIL alu_ctrl[%0d] got stall=%b redirect=%b exp 0/0", k, stall_req, redirect);
            end
            checks++; if (exe_result !== e) begin errors++; $display("FAIL alu_result[%0d] inst=%h got=%h exp=%h", k, v[k].inst, exe_result, e); end
            $display("txn alu inst=%h a=%h b=%h result=%h", v[k].inst, v[k].a, v[k].b, exe_result);
        end
        // non-pipeline opcode (SYSTEM) is not a valid instruction here
        @(posedge clk); #1;
        drive(32'h00000073, 32'd1, 32'd1, 32'd0, 15'h100, 1'b1);
        @(negedge clk);
        checks++; if (result_valid !== 1'b0 || redirect !== 1'b0 || stall_req !== 1'b0) begin
            errors++; $display("FAIL invalid_op got valid=%b redirect=%b stall=%b exp 0/0/0", result_valid, redirect, stall_req);
        end
        $display("txn invalid inst=00000073 valid=%b", result_valid);
    endtask

    task automatic test_branch();
        br_vec_t v[9];
        v[0] = '{32'h00208063, 32'd9,        32'd9,        32'd16,         15'h100,  1'b0, 1'b1, 15'h110};
        v[1] = '{32'h00208063, 32'd9,        32'd9,        32'd16,         15'h100,  1'b1, 1'b0, 15'h110};
        v[2] = '{32'h00209063, 32'd9,        32'd9,        32'd16,         15'h100,  1'b0, 1'b0, 15'h104};
        v[3] = '{32'h00209063, 32'd9,        32'd9,        32'd16,         15'h100,  1'b1, 1'b1, 15'h104};
        v[4] = '{32'h0020C063, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFF0,   15'h100,  1'b0, 1'b1, 15'h0F0};
        v[5] = '{32'h0020F063, 32'd1,        32'hFFFFFFFF, 32'd16,         15'h100,  1'b1, 1'b1, 15'h104};
        v[6] = '{32'h0020D063, 32'hFFFFFFFF, 32'd1,        32'd16,         15'h100,  1'b0, 1'b0, 15'h104};
        v[7] = '{32'h0020E063, 32'd1,        32'hFFFFFFFF, 32'd16,         15'h100,  1'b0, 1'b1, 15'h110};
        v[8] = '{32'h00209063, 32'd9,        32'd9,        32'd16,         15'h7FFC, 1'b1, 1'b1, 15'h000};
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            drive(v[k].inst, v[k].a, v[k].b, v[k].imm, v[k].pc, v[k].bp);
            @(negedge clk);
            checks++; if (redirect !== v[k].exp_redir) begin errors++; $display("FAIL br_redirect[%0d] got=%b exp=%b", k, redirect, v[k].exp_redir); end
            checks++; if (redirect_pc !== v[k].exp_pc) begin errors++; $display("FAIL br_rpc[%0d] got=%h exp=%h", k, redirect_pc, v[k].exp_pc); end
            checks++; if (stall_req !== 1'b0 || result_valid !== 1'b1) begin
                errors++; $display("FAIL br_ctrl[%0d] got stall=%b valid=%b exp 0/1", k, stall_req, result_valid);
            end
            $display("txn branch inst=%h pc=%h bp=%b redirect=%b rpc=%h", v[k].inst, v[k].pc, v[k].bp, redirect, redirect_pc);
        end
        // mispredicted branch killed by flush must not redirect
        @(posedge clk); #1;
        drive(32'h00208063, 32'd9, 32'd9, 32'd16, 15'h100, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        checks++; if (redirect !== 1'b0 || result_valid !== 1'b0) begin
            errors++; $display("FAIL br_flush got redirect=%b valid=%b exp 0/0", redirect, result_valid);
        end
        $display("txn branch flushed redirect=%b", redirect);
        @(posedge clk); #1 flush = 1'b0;
    endtask

    task automatic test_jump();
        logic [31:0] e;
        // JALR with either prediction always redirects; JAL only when predicted not-taken
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k < 2) drive(32'h000080E7, 32'h00000203, 32'd0, 32'd4, 15'h040, k[0]);
            else       drive(32'h000000EF, 32'd0, 32'd0, 32'h00000100, 15'h040, k[0]);
            exp_q.push_back(32'h00000044);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (exe_result !== e || result_valid !== 1'b1) begin
                errors++; $display("FAIL jump_result[%0d] got=%h valid=%b exp=%h valid=1", k, exe_result, result_valid, e);
            end
            checks++; if (redirect !== ((k < 2) ? 1'b1 : !k[0])) begin
                errors++; $display("FAIL jump_redirect[%0d] got=%b exp=%b", k, redirect, (k < 2) ? 1'b1 : !k[0]);
            end
            checks++; if (redirect_pc !== ((k < 2) ? 15'h206 : 15'h140)) begin
                errors++; $display("FAIL jump_rpc[%0d] got=%h exp=%h", k, redirect_pc, (k < 2) ? 15'h206 : 15'h140);
            end
            $display("txn jump k=%0d result=%h redirect=%b rpc=%h", k, exe_result, redirect, redirect_pc);
        end
    endtask

    task automatic test_div();
        div_vec_t v[15];
        int stalls;
        logic done, overlap;
        logic [31:0] res, e;
        v[0]  = '{I_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        v[1]  = '{I_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        v[2]  = '{I_DIVU, 32'd10,       32'd0,        32'hFFFFFFFF, 1};
        v[3]  = '{I_REMU, 32'd10,       32'd0,        32'd10,       1};
        v[4]  = '{I_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        v[5]  = '{I_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        v[6]  = '{I_DIVU, 32'd100,      32'd7,        32'd14,       33};
        v[7]  = '{I_REMU, 32'hFFFFFFFF, 32'd16,       32'd15,       33};
        v[8]  = '{I_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
        v[9]  = '{I_REM,  32'd7,        32'hFFFFFFFE, 32'd1,        33};
        v[10] = '{I_DIV,  32'h80000000, 32'd2,        32'hC0000000, 33};
        v[11] = '{I_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1};
        v[12] = '{I_REM,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1};
        v[13] = '{I_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33};
        v[14] = '{I_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33};
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            exp_q.push_back(v[k].exp);
            run_div(v[k].inst, v[k].a, v[k].b, stalls, done, res, overlap);
            e = exp_q.pop_front();
            checks++; if (stalls != v[k].stalls) begin errors++; $display("FAIL div_stalls[%0d] got=%0d exp=%0d", k, stalls, v[k].stalls); end
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL div_done[%0d] got=%b exp=1", k, done); end
            checks++; if (res !== e) begin errors++; $display("FAIL div_result[%0d] got=%h exp=%h", k, res, e); end
            checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL div_overlap[%0d] got=%b exp=0", k, overlap); end
            $display("txn div inst=%h a=%h b=%h stalls=%0d result=%h", v[k].inst, v[k].a, v[k].b, stalls, res);
        end
    endtask

    // Abort a divide at BUSY cycle 10 by flush (mode 0) or async reset (mode 1).
    task automatic test_abort(input int mode);
        int stalls;
        logic done, overlap;
        logic [31:0] res, e;
        @(posedge clk); #1;
        drive(I_DIV, 32'hFFFFFFF9, 32'd2, 32'd0, 15'h100, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL abort%0d_busy got stall=%b exp=1", mode, stall_req); end
        if (mode == 0) begin
            flush = 1'b1;
            #1;
            checks++; if (stall_req !== 1'b0 || result_valid !== 1'b0 || redirect !== 1'b0) begin
                errors++; $display("FAIL flush_mask got stall=%b valid=%b redirect=%b exp 0/0/0", stall_req, result_valid, redirect);
            end
            @(posedge clk); #1;
            flush = 1'b0;
            drive(32'd0, 32'd0, 32'd0, 32'd0, '0, 1'b0);
        end else begin
            rst = 1'b1;
            drive(32'd0, 32'd0, 32'd0, 32'd0, '0, 1'b0);
            #1;
            checks++; if (stall_req !== 1'b0 || result_valid !== 1'b0 || exe_result !== 32'd0 || redirect_pc !== '0) begin
                errors++; $display("FAIL rst_mask got stall=%b valid=%b result=%h rpc=%h exp 0/0/0/0", stall_req, result_valid, exe_result, redirect_pc);
            end
            #2 rst = 1'b0;
        end
        @(negedge clk);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL abort%0d_idle got stall=%b exp=0", mode, stall_req); end
        @(posedge clk); #1;
        drive(I_ADD, 32'd5, 32'hFFFFFFF9, 32'd0, 15'h100, 1'b0);
        exp_q.push_back(32'hFFFFFFFE);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++; if (result_valid !== 1'b1 || exe_result !== e) begin
            errors++; $display("FAIL abort%0d_add got valid=%b result=%h exp 1/%h", mode, result_valid, exe_result, e);
        end
        $display("txn abort%0d add result=%h", mode, exe_result);
        // a fresh divide must take the full latency from IDLE
        @(posedge clk); #1;
        exp_q.push_back(32'd14);
        run_div(I_DIVU, 32'd100, 32'd7, stalls, done, res, overlap);
        e = exp_q.pop_front();
        checks++; if (stalls != 33 || done !== 1'b1) begin
            errors++; $display("FAIL abort%0d_restart got stalls=%0d done=%b exp 33/1", mode, stalls, done);
        end
        checks++; if (res !== e) begin errors++; $display("FAIL abort%0d_divres got=%h exp=%h", mode, res, e); end
        $display("txn abort%0d div stalls=%0d result=%h", mode, stalls, res);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_jump();
        test_div();
        test_abort(0);
        test_abort(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
